// File: rtl/button_reader_pkg.sv
// Shared types and default timing constants for the button reader.
// DEF_* values assume a 10 MHz system clock.
package button_reader_pkg;

  localparam int DEF_DEBOUNCE_CYCLES = 100000;
  localparam int DEF_LONG_CYCLES     = 10000000;

  typedef enum logic [2:0] {
    RELEASED    = 3'd0,
    PRESS_DEB   = 3'd1,
    HELD        = 3'd2,
    LONG_HELD   = 3'd3,
    RELEASE_DEB = 3'd4
  } state_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous board input.
// RESET_VAL is the idle level, so reset never looks like an input edge.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/button_reader.sv
// Debounced push-button reader: press, long-press and release strobes,
// plus a short-press counter shown active-low on the LEDs.
module button_reader
  import button_reader_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int LONG_CYCLES     = DEF_LONG_CYCLES
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push_button,
  output logic       press_pulse,
  output logic       long_pulse,
  output logic       release_pulse,
  output logic       pressed,
  output logic [7:0] count,
  output logic [7:0] led
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HW = $clog2(LONG_CYCLES + 1);

  localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_MAX  = HW'(LONG_CYCLES);

  logic          smp;
  logic          long_seen;
  state_t        state;
  logic [DW-1:0] deb_cnt;
  logic [HW-1:0] hold_cnt;

  sync_2ff #(
    .RESET_VAL(1'b1)
  ) u_sync (
    .clk(clk),
    .rst(rst),
    .d  (push_button),
    .q  (smp)
  );

  // Saturated hold counter doubles as the "went long" flag.
  assign long_seen = (hold_cnt == HOLD_MAX);

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= RELEASED;
      deb_cnt       <= '0;
      hold_cnt      <= '0;
      press_pulse   <= 1'b0;
      long_pulse    <= 1'b0;
      release_pulse <= 1'b0;
      pressed       <= 1'b0;
      count         <= 8'd0;
      led           <= 8'hFF;
    end else begin
      press_pulse   <= 1'b0;
      long_pulse    <= 1'b0;
      release_pulse <= 1'b0;
      led           <= ~count;
      unique case (state)
        RELEASED: begin
          if (!smp) begin
            state   <= PRESS_DEB;
            deb_cnt <= '0;
          end
        end
        PRESS_DEB: begin
          if (smp) begin
            state <= RELEASED;
          end else if (deb_cnt == DEB_LAST) begin
            state       <= HELD;
            press_pulse <= 1'b1;
            pressed     <= 1'b1;
            hold_cnt    <= '0;
          end else begin
            deb_cnt <= deb_cnt + DW'(1);
          end
        end
        HELD: begin
          if (smp) begin
            state   <= RELEASE_DEB;
            deb_cnt <= '0;
          end else if (hold_cnt == HOLD_LAST) begin
            state      <= LONG_HELD;
            long_pulse <= 1'b1;
            hold_cnt   <= HOLD_MAX;
            count      <= 8'd0;
          end else begin
            hold_cnt <= hold_cnt + HW'(1);
          end
        end
        LONG_HELD: begin
          if (smp) begin
            state   <= RELEASE_DEB;
            deb_cnt <= '0;
          end
        end
        RELEASE_DEB: begin
          if (!smp) begin
            state <= long_seen ? LONG_HELD : HELD;
          end else if (deb_cnt == DEB_LAST) begin
            state         <= RELEASED;
            release_pulse <= 1'b1;
            pressed       <= 1'b0;
            if (!long_seen) count <= count + 8'd1;
          end else begin
            deb_cnt <= deb_cnt + DW'(1);
          end
        end
        default: state <= RELEASED;
      endcase
    end
  end

endmodule

// File: tb/tb_button_reader.sv
// Self-checking bench for button_reader with short debounce/long times.
// Reference model works on run lengths of the synchronized samples.
module tb_button_reader;

  localparam int D = 4;
  localparam int L = 20;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       push_button = 1'b1;
  logic       press_pulse;
  logic       long_pulse;
  logic       release_pulse;
  logic       pressed;
  logic [7:0] count;
  logic [7:0] led;

  button_reader #(
    .DEBOUNCE_CYCLES(D),
    .LONG_CYCLES    (L)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .push_button  (push_button),
    .press_pulse  (press_pulse),
    .long_pulse   (long_pulse),
    .release_pulse(release_pulse),
    .pressed      (pressed),
    .count        (count),
    .led          (led)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int n_press = 0;
  int n_long = 0;
  int n_rel = 0;
  int lat, p0, l0, r0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  logic       m_h1, m_h2, m_level, m_long_seen;
  logic       m_press, m_long, m_rel;
  int         m_run, m_hold;
  logic [7:0] m_count, e_led;

  // m_run counts consecutive samples opposite to the accepted level;
  // m_hold counts stable-held samples since the press was accepted.
  task automatic model_edge(input logic b, input logic r);
    logic smp;
    e_led   = r ? 8'hFF : ~m_count;
    m_press = 1'b0;
    m_long  = 1'b0;
    m_rel   = 1'b0;
    if (r) begin
      m_h1 = 1'b1; m_h2 = 1'b1;
      m_level = 1'b0; m_long_seen = 1'b0;
      m_run = 0; m_hold = 0; m_count = 8'd0;
      return;
    end
    smp  = m_h2;
    m_h2 = m_h1;
    m_h1 = b;
    if (!m_level) begin
      m_run = smp ? 0 : m_run + 1;
      if (m_run == D + 1) begin
        m_level = 1'b1; m_press = 1'b1;
        m_run = 0; m_hold = 0; m_long_seen = 1'b0;
      end
    end else if (smp) begin
      m_run++;
      if (m_run == D + 1) begin
        m_level = 1'b0; m_rel = 1'b1; m_run = 0;
        if (!m_long_seen) m_count = m_count + 8'd1;
      end
    end else begin
      if (m_run == 0 && !m_long_seen) begin
        m_hold++;
        if (m_hold == L) begin
          m_long = 1'b1; m_long_seen = 1'b1; m_count = 8'd0;
        end
      end
      m_run = 0;
    end
  endtask

  task automatic step(input logic b, input logic r);
    @(negedge clk);
    push_button = b;
    rst = r;
    @(posedge clk);
    #1;
    model_edge(b, r);
    check("cycle",
          {press_pulse, long_pulse, release_pulse, pressed, count, led},
          {m_press, m_long, m_rel, m_level, m_count, e_led});
    n_press += int'(press_pulse);
    n_long  += int'(long_pulse);
    n_rel   += int'(release_pulse);
  endtask

  task automatic hold_level(input logic b, input int n);
    for (int i = 0; i < n; i++) step(b, 1'b0);
  endtask

  task automatic do_reset();
    repeat (2) step(1'b1, 1'b1);
    hold_level(1'b1, 3);
  endtask

  initial begin
    // reset held with button low
    repeat (3) step(1'b0, 1'b1);
    check("rst_led", led, 8'hFF);
    check("rst_count", count, 0);
    check("rst_pulses", n_press + n_long + n_rel, 0);
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      step(1'b0, 1'b0);
      if (press_pulse && lat < 0) lat = i;
    end
    check("press_latency", lat - 1, 6);

    // reset mid-press: fresh press, no release
    p0 = n_press; r0 = n_rel;
    repeat (2) step(1'b0, 1'b1);
    hold_level(1'b0, 10);
    check("midrst_press", n_press - p0, 1);
    check("midrst_rel", n_rel - r0, 0);

    // short glitch
    do_reset();
    p0 = n_press;
    hold_level(1'b0, 3);
    hold_level(1'b1, 10);
    check("glitch_press", n_press - p0, 0);
    check("glitch_count", count, 0);
    check("glitch_pressed", pressed, 0);

    // clean short press
    do_reset();
    p0 = n_press; r0 = n_rel;
    hold_level(1'b0, 10);
    hold_level(1'b1, 10);
    check("short_press", n_press - p0, 1);
    check("short_rel", n_rel - r0, 1);
    check("short_count", count, 1);
    check("short_led", led, 8'hFE);

    // long press
    do_reset();
    l0 = n_long; r0 = n_rel;
    hold_level(1'b0, 40);
    check("long_pulse", n_long - l0, 1);
    check("long_count", count, 0);
    hold_level(1'b1, 10);
    check("long_rel", n_rel - r0, 1);
    check("long_count_rel", count, 0);

    // release bounce while held
    do_reset();
    r0 = n_rel;
    hold_level(1'b0, 10);
    hold_level(1'b1, 2);
    hold_level(1'b0, 1);
    hold_level(1'b1, 3);
    check("bounce_norel", n_rel - r0, 0);
    hold_level(1'b1, 7);
    check("bounce_rel", n_rel - r0, 1);
    check("bounce_count", count, 1);

    // wrap 255 -> 0
    do_reset();
    for (int i = 0; i < 255; i++) begin
      hold_level(1'b0, 8);
      hold_level(1'b1, 9);
    end
    check("pre_wrap", count, 255);
    check("pre_wrap_led", led, 8'h00);
    hold_level(1'b0, 8);
    hold_level(1'b1, 9);
    check("wrap_count", count, 0);
    check("wrap_led", led, 8'hFF);

    // random runs with occasional resets
    do_reset();
    for (int s = 0; s < 200; s++) begin
      logic lvl;
      int   len;
      lvl = s[0];
      len = int'($urandom_range(1, 30));
      for (int k = 0; k < len; k++)
        step(lvl, ($urandom_range(0, 199) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/button_reader.md
BUTTON_READER -- requirements
Module: button_reader

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 100000, number of consecutive stable samples required to accept a level change (10 ms at 10 MHz).
REQ-002 Parameter LONG_CYCLES, default 10000000, accepted-press hold time before a long press is declared (1 s at 10 MHz).
REQ-003 Port clk, input, 1, 10 MHz system clock; the only clock.
REQ-004 Port rst, input, 1, synchronous active-high reset, sampled on the rising edge of clk.
REQ-005 Port push_button, input, 1, asynchronous raw button; active-low, 0 = pressed.
REQ-006 Port press_pulse, output, 1, one-cycle strobe when a press is accepted.
REQ-007 Port long_pulse, output, 1, one-cycle strobe when an accepted press reaches LONG_CYCLES.
REQ-008 Port release_pulse, output, 1, one-cycle strobe when a release is accepted.
REQ-009 Port pressed, output, 1, debounced level; 1 while in HELD, LONG_HELD or RELEASE_DEB.
REQ-010 Port count, output, 8, accepted short-press counter.
REQ-011 Port led, output, 8, active-low display of count; led = ~count, registered.

Function
REQ-012 push_button SHALL pass through a 2-flop synchronizer; all logic uses the synchronized sample only.
REQ-013 FSM states: RELEASED, PRESS_DEB, HELD, LONG_HELD, RELEASE_DEB.
REQ-014 RELEASED: sample low -> PRESS_DEB, debounce counter cleared.
REQ-015 PRESS_DEB: sample high -> RELEASED (bounce rejected, no pulse); DEBOUNCE_CYCLES consecutive low samples -> HELD with press_pulse high for that one cycle.
REQ-016 Resulting latency: with push_button held low and stable, press_pulse is high exactly DEBOUNCE_CYCLES+2 cycles after the first edge that registers push_button low in the first sync flop.
REQ-017 HELD: hold counter increments each cycle; on reaching LONG_CYCLES -> LONG_HELD with long_pulse high for one cycle; sample high -> RELEASE_DEB.
REQ-018 RELEASE_DEB: sample low -> return to the held state it came from (HELD or LONG_HELD), hold counter preserved; DEBOUNCE_CYCLES consecutive high samples -> RELEASED with release_pulse high for one cycle.
REQ-019 The hold counter SHALL not advance during RELEASE_DEB and SHALL saturate; long_pulse fires at most once per press.
REQ-020 count SHALL increment on release_pulse only when the press never reached LONG_HELD; wraps 255 -> 0.
REQ-021 long_pulse SHALL clear count to 0 in the same cycle; the subsequent release does not increment.
REQ-022 At most one of press_pulse, long_pulse, release_pulse is high in any cycle.
REQ-023 led SHALL update one cycle after count changes.
REQ-024 Counter widths SHALL be derived from the parameters via $clog2; no truncation at default values.

Reset
REQ-025 While rst is high: state RELEASED, sync flops 1 (released), debounce/hold counters 0, count 0, led 8'hFF, all pulses 0, pressed 0.
REQ-026 Reset mid-press: a button still held when rst deasserts SHALL be re-debounced and produce a fresh press_pulse; no release_pulse is generated for the interrupted press.

Structure
REQ-027 A shared package SHALL hold the FSM state encoding and the default DEBOUNCE_CYCLES/LONG_CYCLES constants.
REQ-028 The 2-flop synchronizer SHALL be a separate sub-module, sync_2ff, reusable for other board inputs.

Verification (DEBOUNCE_CYCLES=4, LONG_CYCLES=20)
REQ-029 Reset held 3 cycles with push_button=0 -> led=8'hFF, count=0, no pulses; after release, press_pulse exactly 6 cycles after the first low sample.
REQ-030 Low glitch of 3 cycles then high -> no press_pulse, count stays 0, state returns to RELEASED.
REQ-031 Clean press 10 cycles then release -> press_pulse once, release_pulse once, count=1, led=8'hFE one cycle later.
REQ-032 Press held 40 cycles -> long_pulse once, count cleared to 0, release gives release_pulse and count remains 0.
REQ-033 Preload 255 short presses then one more -> count wraps to 0, led=8'hFF.
REQ-034 Release bounce (high 2 cycles, low 1, then high) while HELD -> no release_pulse until 4 stable high samples; single release_pulse, count +1.
